mem_sync_bridge: RTL

//  Bridge from the self-timed CPU memory port to a clocked memory/peripheral bus.

---
 rtl/mem_bridge_pkg.sv | 18 +
 rtl/mem_sync_bridge_sync_ff.sv | 30 +++
 rtl/mem_sync_bridge.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared token codes and FSM state encoding for the async-to-clocked memory bridge.
package mem_bridge_pkg;

    localparam logic [1:0] TOK_SPACER  = 2'b00;
    localparam logic [1:0] TOK_READ    = 2'b10;
    localparam logic [1:0] TOK_WRITE   = 2'b01;
    localparam logic [1:0] TOK_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        BUS,
        ACK,
        RTZ,
        DRAIN
    } state_t;

endpackage

// File: rtl/mem_sync_bridge_sync_ff.sv
// Multi-flop synchronizer for signals arriving from the self-timed side.
// STAGES must be at least 2.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q_reg <= '0;
                else        q_reg <= d;
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q_reg <= '0;
                else        q_reg <= g_stage[gi-1].q_reg;
            end
        end
    end

    assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/mem_sync_bridge.sv
// Bridge from the four-phase CPU memory token to a single clocked bus transfer,
// returning a four-phase ack_read/ack_write and read data to the async side.
module mem_sync_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        read_Nwrite,
    input  logic              ack_in_read,
    output logic [DATA_W-1:0] data_out,
    output logic              ack_read,
    output logic              ack_write,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err_illegal,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        tok_s;
    logic              ack_in_s;
    logic [1:0]        tok_prev_reg;
    logic              tok_stable;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_ill_reg, err_ill_next;
    logic              err_to_reg, err_to_next;
    logic              set_ill, set_to;

    sync_ff #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_tok_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (read_Nwrite),
        .q     (tok_s)
    );

    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_in_read),
        .q     (ack_in_s)
    );

    // A token only counts once the synchronized value has held for two cycles.
    assign tok_stable = (tok_s == tok_prev_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        set_ill    = 1'b0;
        set_to     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tok_stable) begin
                    if ((tok_s == TOK_READ || tok_s == TOK_WRITE) && !ack_in_s) begin
                        state_next = CAPTURE;
                    end else if (tok_s == TOK_ILLEGAL) begin
                        set_ill    = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            CAPTURE: begin
                addr_next  = addr;
                wdata_next = data_in;
                we_next    = (tok_s == TOK_WRITE);
                cnt_next   = '0;
                state_next = BUS;
            end
            BUS: begin
                if (bus_ready) begin
                    if (!we_reg) rdata_next = bus_rdata;
                    state_next = ACK;
                end else if (cnt_reg == CNT_LAST) begin
                    // Abort so the async side always gets an ack.
                    if (!we_reg) rdata_next = '0;
                    cnt_next   = cnt_reg + 1'b1;
                    set_to     = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ACK: begin
                if (tok_s == TOK_SPACER) state_next = RTZ;
            end
            RTZ: begin
                if (we_reg || !ack_in_s) state_next = IDLE;
            end
            DRAIN: begin
                if (tok_s == TOK_SPACER) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A new error in the same cycle as err_clr stays set.
        err_ill_next = (err_ill_reg & ~err_clr) | set_ill;
        err_to_next  = (err_to_reg & ~err_clr) | set_to;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tok_prev_reg <= TOK_SPACER;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            err_ill_reg  <= 1'b0;
            err_to_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tok_prev_reg <= tok_s;
            cnt_reg      <= cnt_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            err_ill_reg  <= err_ill_next;
            err_to_reg   <= err_to_next;
        end
    end

    assign bus_valid   = (state_reg == BUS);
    assign bus_we      = we_reg;
    assign bus_addr    = addr_reg;
    assign bus_wdata   = wdata_reg;
    assign data_out    = rdata_reg;
    assign ack_read    = (state_reg == ACK) && !we_reg;
    assign ack_write   = (state_reg == ACK) && we_reg;
    assign err_illegal = err_ill_reg;
    assign err_timeout = err_to_reg;

endmodule
